// File: rtl/vec_store_sequencer_if.sv
// Bus bundle between the core/decode side, the vector store sequencer and data memory.
// The slave modport is the sequencer's view; master is the surrounding core/memory side.
interface vec_store_sequencer_if;
    logic        VecStart;
    logic [2:0]  VecLen;
    logic [31:0] BaseAddr;
    logic [31:0] VecWriteData_0;
    logic [31:0] VecWriteData_1;
    logic [31:0] VecWriteData_2;
    logic [31:0] VecWriteData_3;
    logic [31:0] VecWriteData_4;
    logic        CoreMemWrite;
    logic [31:0] CoreAddr;
    logic [31:0] CoreWData;
    logic        MemReady;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        Stall;
    logic        Busy;
    logic        Done;
    logic        Error;

    modport master (
        output VecStart, VecLen, BaseAddr,
        output VecWriteData_0, VecWriteData_1, VecWriteData_2, VecWriteData_3, VecWriteData_4,
        output CoreMemWrite, CoreAddr, CoreWData, MemReady,
        input  MemWE, MemAddr, MemWData, Stall, Busy, Done, Error
    );

    modport slave (
        input  VecStart, VecLen, BaseAddr,
        input  VecWriteData_0, VecWriteData_1, VecWriteData_2, VecWriteData_3, VecWriteData_4,
        input  CoreMemWrite, CoreAddr, CoreWData, MemReady,
        output MemWE, MemAddr, MemWData, Stall, Busy, Done, Error
    );
endinterface

// File: rtl/vec_store_sequencer.sv
// Serialises a latched multi-lane vector store onto the shared data-memory write port,
// stalling the core while beats are issued and aborting a beat that waits too long.
module vec_store_sequencer #(
    parameter int NUM_LANES   = 5,
    parameter int ADDR_STRIDE = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    vec_store_sequencer_if.slave  bus
);
    localparam int          TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [31:0] STRIDE = 32'(ADDR_STRIDE);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] lanes_reg [0:NUM_LANES-1];
    logic [31:0] lane_in   [0:4];
    logic [2:0]  len_reg;
    logic [31:0] base_reg;
    logic [2:0]  beat_reg;
    logic [TMO_W-1:0] tmo_reg;
    logic        abort_reg;
    logic        inv_err_reg;

    logic valid_start;
    logic load;
    logic beat_accept;
    logic last_beat;
    logic timeout_hit;

    assign lane_in[0] = bus.VecWriteData_0;
    assign lane_in[1] = bus.VecWriteData_1;
    assign lane_in[2] = bus.VecWriteData_2;
    assign lane_in[3] = bus.VecWriteData_3;
    assign lane_in[4] = bus.VecWriteData_4;

    assign valid_start = bus.VecStart && (bus.VecLen != 3'd0) &&
                         (bus.VecLen <= 3'(NUM_LANES)) && (bus.BaseAddr[1:0] == 2'b00);
    assign load        = (state_reg == IDLE) && valid_start;
    assign beat_accept = (state_reg == WRITE) && bus.MemReady;
    assign last_beat   = (beat_reg == len_reg - 3'd1);
    assign timeout_hit = (state_reg == WRITE) && !bus.MemReady &&
                         (tmo_reg == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (valid_start) state_next = WRITE;
            WRITE:   if ((beat_accept && last_beat) || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane data is captured once at start so the core may move on to other values.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lanes_reg[gi] <= '0;
                end else if (load) begin
                    lanes_reg[gi] <= lane_in[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_reg     <= '0;
            base_reg    <= '0;
            beat_reg    <= '0;
            tmo_reg     <= '0;
            abort_reg   <= 1'b0;
            inv_err_reg <= 1'b0;
        end else begin
            inv_err_reg <= (state_reg == IDLE) && bus.VecStart && !valid_start;
            if (load) begin
                len_reg   <= bus.VecLen;
                base_reg  <= bus.BaseAddr;
                beat_reg  <= '0;
                tmo_reg   <= '0;
                abort_reg <= 1'b0;
            end else if (state_reg == WRITE) begin
                if (bus.MemReady) begin
                    beat_reg <= beat_reg + 3'd1;
                    tmo_reg  <= '0;
                end else begin
                    tmo_reg <= tmo_reg + TMO_W'(1);
                end
                if (timeout_hit) abort_reg <= 1'b1;
            end
        end
    end

    // Outputs are forced low while reset is held so the core is released without waiting for a clock.
    always_comb begin
        bus.MemWE    = bus.CoreMemWrite;
        bus.MemAddr  = bus.CoreAddr;
        bus.MemWData = bus.CoreWData;
        bus.Stall    = 1'b0;
        bus.Busy     = 1'b0;
        bus.Done     = 1'b0;
        bus.Error    = inv_err_reg;
        case (state_reg)
            IDLE: begin
                bus.Stall = valid_start;
            end
            WRITE: begin
                bus.Stall    = 1'b1;
                bus.Busy     = 1'b1;
                bus.MemWE    = 1'b1;
                bus.MemAddr  = base_reg + 32'(beat_reg) * STRIDE;
                bus.MemWData = lanes_reg[beat_reg];
            end
            DONE: begin
                bus.Busy  = 1'b1;
                bus.Done  = 1'b1;
                bus.Error = inv_err_reg || abort_reg;
            end
            default: ;
        endcase
        if (!reset) begin
            bus.MemWE = 1'b0;
            bus.Stall = 1'b0;
            bus.Busy  = 1'b0;
            bus.Done  = 1'b0;
            bus.Error = 1'b0;
        end
    end
endmodule

// File: tb/tb_vec_store_sequencer.sv
// Scoreboard bench for vec_store_sequencer: expected beats are queued when a store is
// launched and popped as the memory port accepts vector writes.
module tb_vec_store_sequencer;
    localparam int NUM_LANES   = 5;
    localparam int ADDR_STRIDE = 4;
    localparam int TIMEOUT     = 15;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   check_cnt = 0;
    int   error_cnt = 0;
    wr_t  exp_q[$];
    logic [31:0] lane_val [0:4];

    int st, dn, er, bt;

    vec_store_sequencer_if vif();

    vec_store_sequencer #(
        .NUM_LANES   (NUM_LANES),
        .ADDR_STRIDE (ADDR_STRIDE),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Scoreboard: every accepted vector beat must match the head of the queue.
    always @(negedge clk) begin
        wr_t e;
        if (vif.MemWE && vif.MemReady && vif.Busy && vif.Stall) begin
            check_val("vec_write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_val("vec_write_addr", vif.MemAddr, e.addr);
                check_val("vec_write_data", vif.MemWData, e.data);
                $display("t=%0t write addr=0x%08h data=0x%08h", $time, vif.MemAddr, vif.MemWData);
            end
        end
    end

    task automatic drive_lanes();
        vif.VecWriteData_0 = lane_val[0];
        vif.VecWriteData_1 = lane_val[1];
        vif.VecWriteData_2 = lane_val[2];
        vif.VecWriteData_3 = lane_val[3];
        vif.VecWriteData_4 = lane_val[4];
    endtask

    task automatic scramble_lanes();
        vif.VecWriteData_0 = $urandom;
        vif.VecWriteData_1 = $urandom;
        vif.VecWriteData_2 = $urandom;
        vif.VecWriteData_3 = $urandom;
        vif.VecWriteData_4 = $urandom;
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge with VecStart low.
    task automatic do_store(input logic [2:0] len, input logic [31:0] base,
                            input int hold_beat, input int hold_cycles, input int n_push,
                            output int stall_n, output int done_at, output int err_n,
                            output int beats);
        int waited;
        int cyc;
        waited  = 0;
        cyc     = 0;
        stall_n = 0;
        done_at = -1;
        err_n   = 0;
        beats   = 0;
        for (int k = 0; k < n_push; k++)
            exp_q.push_back('{addr: base + 32'(k) * 32'(ADDR_STRIDE), data: lane_val[k]});
        drive_lanes();
        vif.VecStart = 1'b1;
        vif.VecLen   = len;
        vif.BaseAddr = base;
        while (cyc < 60) begin
            vif.MemReady = !(beats == hold_beat && waited < hold_cycles);
            @(negedge clk);
            if (vif.Stall) stall_n++;
            if (vif.Error) err_n++;
            if (vif.Busy && vif.Stall) begin
                check_val("write_we", 32'(vif.MemWE), 32'd1);
                check_val("beat_addr", vif.MemAddr, base + 32'(beats) * 32'(ADDR_STRIDE));
                if (beats < 5) check_val("beat_data", vif.MemWData, lane_val[beats]);
                if (vif.MemReady) beats++;
                else waited++;
            end
            if (vif.Done) begin
                done_at = cyc;
                check_val("done_stall", 32'(vif.Stall), 32'd0);
                check_val("done_busy", 32'(vif.Busy), 32'd1);
                break;
            end
            @(posedge clk); #1;
            cyc++;
            scramble_lanes();
        end
        @(posedge clk); #1;
        vif.VecStart = 1'b0;
        vif.MemReady = 1'b1;
        @(negedge clk);
        check_val("post_done", 32'(vif.Done), 32'd0);
        check_val("post_busy", 32'(vif.Busy), 32'd0);
        check_val("post_error", 32'(vif.Error), 32'd0);
        $display("store len=%0d base=0x%08h stall=%0d done_at=%0d err=%0d beats=%0d",
                 len, base, stall_n, done_at, err_n, beats);
        @(posedge clk); #1;
    endtask

    logic [2:0]  bad_len  [0:2];
    logic [31:0] bad_base [0:2];

    initial begin
        reset            = 1'b0;
        vif.VecStart     = 1'b0;
        vif.VecLen       = 3'd0;
        vif.BaseAddr     = '0;
        vif.CoreMemWrite = 1'b0;
        vif.CoreAddr     = '0;
        vif.CoreWData    = '0;
        vif.MemReady     = 1'b1;
        for (int k = 0; k < 5; k++) lane_val[k] = '0;
        drive_lanes();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_stall", 32'(vif.Stall), 32'd0);
        check_val("rst_busy",  32'(vif.Busy),  32'd0);
        check_val("rst_done",  32'(vif.Done),  32'd0);
        check_val("rst_error", 32'(vif.Error), 32'd0);
        check_val("rst_we",    32'(vif.MemWE), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_val("idle_we",   32'(vif.MemWE), 32'd0);
        check_val("idle_busy", 32'(vif.Busy),  32'd0);

        // Scalar passthrough in IDLE
        @(posedge clk); #1;
        vif.CoreMemWrite = 1'b1;
        vif.CoreAddr     = 32'h20;
        vif.CoreWData    = 32'h55;
        @(negedge clk);
        check_val("pt_we",    32'(vif.MemWE), 32'd1);
        check_val("pt_addr",  vif.MemAddr, 32'h20);
        check_val("pt_data",  vif.MemWData, 32'h55);
        check_val("pt_stall", 32'(vif.Stall), 32'd0);
        @(posedge clk); #1;
        vif.CoreMemWrite = 1'b0;

        // Full 5-lane store, no wait states
        for (int k = 0; k < 5; k++) lane_val[k] = 32'hA0 + 32'(k);
        do_store(3'd5, 32'h100, -1, 0, 5, st, dn, er, bt);
        check_val("t1_stall_cycles", st, 32'd6);
        check_val("t1_done_cycle",   dn, 32'd6);
        check_val("t1_error",        er, 32'd0);
        check_val("t1_beats",        bt, 32'd5);

        // Two wait states on beat 1
        for (int k = 0; k < 5; k++) lane_val[k] = 32'hB0 + 32'(k);
        do_store(3'd3, 32'h200, 1, 2, 3, st, dn, er, bt);
        check_val("t2_stall_cycles", st, 32'd6);
        check_val("t2_done_cycle",   dn, 32'd6);
        check_val("t2_error",        er, 32'd0);
        check_val("t2_beats",        bt, 32'd3);

        // MemReady never rises: timeout abort on beat 0
        for (int k = 0; k < 5; k++) lane_val[k] = 32'hD0 + 32'(k);
        do_store(3'd2, 32'h300, 0, 1000, 0, st, dn, er, bt);
        check_val("t3_stall_cycles", st, 32'(TIMEOUT + 1));
        check_val("t3_done_cycle",   dn, 32'(TIMEOUT + 1));
        check_val("t3_error",        er, 32'd1);
        check_val("t3_beats",        bt, 32'd0);
        check_val("t3_queue_empty",  32'(exp_q.size()), 32'd0);

        // Invalid starts: zero length, too long, misaligned
        bad_len[0] = 3'd0; bad_base[0] = 32'h100;
        bad_len[1] = 3'd6; bad_base[1] = 32'h100;
        bad_len[2] = 3'd2; bad_base[2] = 32'h102;
        for (int i = 0; i < 3; i++) begin
            vif.VecStart     = 1'b1;
            vif.VecLen       = bad_len[i];
            vif.BaseAddr     = bad_base[i];
            vif.CoreMemWrite = 1'b1;
            vif.CoreAddr     = 32'h40 + 32'(i);
            vif.CoreWData    = 32'h70 + 32'(i);
            @(negedge clk);
            check_val("inv_stall", 32'(vif.Stall), 32'd0);
            check_val("inv_we",    32'(vif.MemWE), 32'd1);
            check_val("inv_addr",  vif.MemAddr, 32'h40 + 32'(i));
            check_val("inv_err_same_cycle", 32'(vif.Error), 32'd0);
            @(posedge clk); #1;
            vif.VecStart     = 1'b0;
            vif.CoreMemWrite = 1'b0;
            @(negedge clk);
            check_val("inv_err_pulse", 32'(vif.Error), 32'd1);
            check_val("inv_busy",      32'(vif.Busy),  32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check_val("inv_err_clear", 32'(vif.Error), 32'd0);
            $display("invalid start len=%0d base=0x%08h", bad_len[i], bad_base[i]);
            @(posedge clk); #1;
        end

        // Reset asserted while beat 3 of 5 is pending
        for (int k = 0; k < 5; k++) lane_val[k] = 32'hC0 + 32'(k);
        for (int k = 0; k < 3; k++)
            exp_q.push_back('{addr: 32'h400 + 32'(k) * 32'(ADDR_STRIDE), data: lane_val[k]});
        drive_lanes();
        vif.VecStart = 1'b1;
        vif.VecLen   = 3'd5;
        vif.BaseAddr = 32'h400;
        vif.MemReady = 1'b1;
        @(negedge clk);
        check_val("t5_start_stall", 32'(vif.Stall), 32'd1);
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        vif.MemReady = 1'b0;
        @(negedge clk);
        check_val("t5_beat3_addr", vif.MemAddr, 32'h40C);
        #1;
        reset = 1'b0;
        #1;
        check_val("t5_rst_we",    32'(vif.MemWE), 32'd0);
        check_val("t5_rst_stall", 32'(vif.Stall), 32'd0);
        check_val("t5_rst_busy",  32'(vif.Busy),  32'd0);
        check_val("t5_queue",     32'(exp_q.size()), 32'd0);
        $display("reset asserted mid-store");
        @(posedge clk); #1;
        vif.VecStart = 1'b0;
        @(posedge clk); #1;
        reset            = 1'b1;
        vif.MemReady     = 1'b1;
        vif.CoreMemWrite = 1'b1;
        vif.CoreAddr     = 32'h60;
        vif.CoreWData    = 32'h88;
        @(negedge clk);
        check_val("t5_pt_we",   32'(vif.MemWE), 32'd1);
        check_val("t5_pt_addr", vif.MemAddr, 32'h60);
        check_val("t5_pt_data", vif.MemWData, 32'h88);
        @(posedge clk); #1;
        vif.CoreMemWrite = 1'b0;
        for (int k = 0; k < 5; k++) lane_val[k] = 32'hE0 + 32'(k);
        do_store(3'd2, 32'h500, -1, 0, 2, st, dn, er, bt);
        check_val("t5_new_stall", st, 32'd3);
        check_val("t5_new_done",  dn, 32'd3);
        check_val("t5_new_beats", bt, 32'd2);
        check_val("final_queue",  32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end
endmodule
